// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: ALUControl codes, MIPS opcode/funct fields and the
// decoded issue payload carried from ID to EX. The ALU imports the same codes.
package alu_defs_pkg;

  // ALUControl encodings
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_NOR     = 4'b0011;
  localparam logic [3:0] ALU_XOR     = 4'b0100;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_JUMP    = 4'b1000;
  localparam logic [3:0] ALU_MUL     = 4'b1001;
  localparam logic [3:0] ALU_SLL     = 4'b1010;
  localparam logic [3:0] ALU_SGT     = 4'b1011;
  localparam logic [3:0] ALU_CLO_CLZ = 4'b1100;
  localparam logic [3:0] ALU_ROTR    = 4'b1101;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SW       = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] F_SLL       = 6'b000000;
  localparam logic [5:0] F_SRL_ROTR  = 6'b000010;
  localparam logic [5:0] F_JR        = 6'b001000;
  localparam logic [5:0] F_ADD       = 6'b100000;
  localparam logic [5:0] F_ADDU      = 6'b100001;
  localparam logic [5:0] F_SUB       = 6'b100010;
  localparam logic [5:0] F_SUBU      = 6'b100011;
  localparam logic [5:0] F_AND       = 6'b100100;
  localparam logic [5:0] F_OR        = 6'b100101;
  localparam logic [5:0] F_XOR       = 6'b100110;
  localparam logic [5:0] F_NOR       = 6'b100111;
  localparam logic [5:0] F_SLT       = 6'b101010;
  localparam logic [5:0] F_SLTU      = 6'b101011;

  // SPECIAL2 funct codes
  localparam logic [5:0] S2_MUL      = 6'b000010;
  localparam logic [5:0] S2_CLZ      = 6'b100000;
  localparam logic [5:0] S2_CLO      = 6'b100001;

  localparam int SHAMT_W_DEFAULT = 5;

  // Decoded payload stored per buffer entry (69 bits)
  typedef struct packed {
    logic        illegal;
    logic [3:0]  alu_ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } issue_payload_t;

  localparam issue_payload_t ILLEGAL_PAYLOAD = '{1'b1, 4'b0000, 32'd0, 32'd0};

  function automatic issue_payload_t make_payload(input logic [3:0]  ctrl,
                                                  input logic [31:0] a,
                                                  input logic [31:0] b);
    return '{1'b0, ctrl, a, b};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational decode of a MIPS instruction plus register operands into
// the ALUControl code and final A/B operands.
module alu_op_decode
  import alu_defs_pkg::*;
#(
  parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
  input  logic [31:0]    instr_i,
  input  logic [31:0]    rs_data_i,
  input  logic [31:0]    rt_data_i,
  output issue_payload_t payload_o
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] shamt_zext;
  logic        unused_instr_bits;

  assign opcode     = instr_i[31:26];
  assign funct      = instr_i[5:0];
  assign imm_sext   = {{16{instr_i[15]}}, instr_i[15:0]};
  assign imm_zext   = {16'h0000, instr_i[15:0]};
  assign shamt_zext = {{(32 - SHAMT_W){1'b0}}, instr_i[6 +: SHAMT_W]};

  // Register specifiers are resolved by the register file, not here.
  assign unused_instr_bits = ^{instr_i[25:22], instr_i[20:16]};

  // Opcode/funct lookup; anything not listed falls through to the illegal payload.
  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    payload_o = ILLEGAL_PAYLOAD;
    unique case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: payload_o = make_payload(ALU_ADD, rs_data_i, rt_data_i);
          F_SUB, F_SUBU: payload_o = make_payload(ALU_SUB, rs_data_i, rt_data_i);
          F_AND:         payload_o = make_payload(ALU_AND, rs_data_i, rt_data_i);
          F_OR:          payload_o = make_payload(ALU_OR,  rs_data_i, rt_data_i);
          F_XOR:         payload_o = make_payload(ALU_XOR, rs_data_i, rt_data_i);
          F_NOR:         payload_o = make_payload(ALU_NOR, rs_data_i, rt_data_i);
          F_SLT, F_SLTU: payload_o = make_payload(ALU_SLT, rs_data_i, rt_data_i);
          F_SLL:         payload_o = make_payload(ALU_SLL, rt_data_i, shamt_zext);
          F_SRL_ROTR: begin
            // Only the rotate form (R bit set) is supported; plain srl is illegal.
            if (instr_i[21]) payload_o = make_payload(ALU_ROTR, rt_data_i, shamt_zext);
          end
          F_JR:          payload_o = make_payload(ALU_JUMP, 32'd0, 32'd0);
          default:       payload_o = ILLEGAL_PAYLOAD;
        endcase
      end
      OP_SPECIAL2: begin
        case (funct)
          S2_MUL:  payload_o = make_payload(ALU_MUL,     rs_data_i, rt_data_i);
          S2_CLO:  payload_o = make_payload(ALU_CLO_CLZ, rs_data_i, 32'd1);
          S2_CLZ:  payload_o = make_payload(ALU_CLO_CLZ, rs_data_i, 32'd0);
          default: payload_o = ILLEGAL_PAYLOAD;
        endcase
      end
      OP_ADDI, OP_ADDIU,
      OP_LW, OP_SW, OP_LB, OP_LH, OP_SB, OP_SH:
                 payload_o = make_payload(ALU_ADD, rs_data_i, imm_sext);
      OP_SLTI:   payload_o = make_payload(ALU_SLT, rs_data_i, imm_sext);
      OP_ANDI:   payload_o = make_payload(ALU_AND, rs_data_i, imm_zext);
      OP_ORI:    payload_o = make_payload(ALU_OR,  rs_data_i, imm_zext);
      OP_XORI:   payload_o = make_payload(ALU_XOR, rs_data_i, imm_zext);
      OP_BEQ, OP_BNE:
                 payload_o = make_payload(ALU_SUB, rs_data_i, rt_data_i);
      OP_LUI:    payload_o = make_payload(ALU_SLL, imm_zext, 32'd16);
      OP_J, OP_JAL:
                 payload_o = make_payload(ALU_JUMP, 32'd0, 32'd0);
      default:   payload_o = ILLEGAL_PAYLOAD;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the incoming instruction and holds the result in
// a 2-entry skid buffer behind a valid/ready handshake. Entry0 drives the
// outputs, entry1 absorbs the one extra instruction accepted during a stall.
// DEPTH documents the fixed two-entry structure; only 2 is supported.
module alu_issue_stage
  import alu_defs_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Flush,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] Instr,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [3:0]  ALUControl,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        Illegal
);

  issue_payload_t dec_payload;
  issue_payload_t e0_q, e0_d, e1_q, e1_d, out_payload;
  logic           e0_valid_q, e0_valid_d;
  logic           e1_valid_q, e1_valid_d;
  logic           push, pop;

  alu_op_decode #(.SHAMT_W(SHAMT_W)) u_decode (
    .instr_i   (Instr),
    .rs_data_i (RsData),
    .rt_data_i (RtData),
    .payload_o (dec_payload)
  );

  // Ready comes straight from a flop, so it never depends on OutReady.
  assign InReady = !e1_valid_q;
  assign push    = InValid && InReady;
  assign pop     = e0_valid_q && OutReady;

  // Buffer next state: flush wins; otherwise pop shifts entry1 down, then push fills the first free slot.
  always_comb begin
    e0_valid_d = e0_valid_q;
    e1_valid_d = e1_valid_q;
    e0_d       = e0_q;
    e1_d       = e1_q;
    if (Flush) begin
      e0_valid_d = 1'b0;
      e1_valid_d = 1'b0;
    end else begin
      if (pop) begin
        e0_valid_d = e1_valid_q;
        e0_d       = e1_q;
        e1_valid_d = 1'b0;
      end
      if (push) begin
        if (!e0_valid_d) begin
          e0_valid_d = 1'b1;
          e0_d       = dec_payload;
        end else begin
          e1_valid_d = 1'b1;
          e1_d       = dec_payload;
        end
      end
    end
  end

  // Entry valid flags with synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (Reset) begin
      e0_valid_q <= 1'b0;
      e1_valid_q <= 1'b0;
    end else begin
      e0_valid_q <= e0_valid_d;
      e1_valid_q <= e1_valid_d;
    end
  end

  // Entry payload storage.
  always_ff @(posedge Clk) begin
    // NOTE: payload storage is not reset; the valid flags qualify it and outputs are gated below.
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

  // Outputs read zero whenever entry0 is empty, which gives the reset values for free.
  assign out_payload = e0_valid_q ? e0_q : '0;
  assign OutValid    = e0_valid_q;
  assign Illegal     = out_payload.illegal;
  assign ALUControl  = out_payload.alu_ctrl;
  assign A           = out_payload.a;
  assign B           = out_payload.b;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: expected payloads are queued when an
// instruction is accepted and compared as the EX side takes each output.
module tb_alu_issue_stage;

  logic        Clk = 1'b0;
  logic        Reset, Flush, InValid, OutReady;
  logic        InReady, OutValid, Illegal;
  logic [31:0] Instr, RsData, RtData, A, B;
  logic [3:0]  ALUControl;

  int compared   = 0;
  int mismatched = 0;

  logic [68:0] sb[$];

  localparam logic [31:0] RS = 32'h8000_0010;
  localparam logic [31:0] RT = 32'h0000_0007;

  alu_issue_stage dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .Instr(Instr), .RsData(RsData), .RtData(RtData),
    .OutValid(OutValid), .OutReady(OutReady),
    .ALUControl(ALUControl), .A(A), .B(B), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every output transfer must match the oldest accepted instruction.
  always @(negedge Clk) begin
    if (OutValid && OutReady) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected: got %h, expected no output", {Illegal, ALUControl, A, B});
      end else begin
        logic [68:0] exp;
        exp = sb.pop_front();
        if ({Illegal, ALUControl, A, B} !== exp) begin
          mismatched++;
          $display("FAIL sb_payload: got %h, expected %h", {Illegal, ALUControl, A, B}, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [68:0] exp);
    InValid = 1'b1; Instr = instr; RsData = rs; RtData = rt;
    for (int i = 0; i < 20 && !InReady; i++) tick();
    compared++;
    if (!InReady) begin
      mismatched++;
      $display("FAIL send_timeout: InReady=%b, expected 1 within 20 cycles", InReady);
    end else begin
      sb.push_back(exp);
    end
    tick();
    InValid = 1'b0;
  endtask

  task automatic drain();
    OutReady = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    compared++;
    if (sb.size() != 0 || OutValid !== 1'b0) begin
      mismatched++;
      $display("FAIL drain: %0d left, OutValid=%b, expected 0 left and OutValid=0", sb.size(), OutValid);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    Instr = '0; RsData = '0; RtData = '0;
    tick(); tick();
    Reset = 1'b0;
    compared++;
    if ({OutValid, InReady, Illegal, ALUControl, A, B} !== {1'b0, 1'b1, 1'b0, 4'd0, 64'd0}) begin
      mismatched++;
      $display("FAIL reset_state: got ov=%b ir=%b il=%b ctl=%h a=%h b=%h, expected ov=0 ir=1 all zero",
               OutValid, InReady, Illegal, ALUControl, A, B);
    end
  endtask

  task automatic test_add();
    logic [68:0] exp;
    exp = {1'b0, 4'b0010, 32'd5, 32'd7};
    OutReady = 1'b1;
    InValid = 1'b1; Instr = 32'h0022_1820; RsData = 32'd5; RtData = 32'd7;
    sb.push_back(exp);
    tick();
    InValid = 1'b0;
    compared++;
    if (OutValid !== 1'b1 || {Illegal, ALUControl, A, B} !== exp) begin
      mismatched++;
      $display("FAIL add_latency: got ov=%b %h, expected ov=1 %h", OutValid, {Illegal, ALUControl, A, B}, exp);
    end
    drain();
  endtask

  task automatic test_decode_sweep();
    OutReady = 1'b1;
    send(32'h2022_FFFF, RS, RT, {1'b0, 4'b0010, RS, 32'hFFFF_FFFF}); // addi -1
    send(32'h3022_FFFF, RS, RT, {1'b0, 4'b0000, RS, 32'h0000_FFFF}); // andi
    send(32'h3C02_1234, RS, RT, {1'b0, 4'b1010, 32'h0000_1234, 32'd16}); // lui
    send(32'h7020_1821, RS, RT, {1'b0, 4'b1100, RS, 32'd1});         // clo
    send(32'h7020_1820, RS, RT, {1'b0, 4'b1100, RS, 32'd0});         // clz
    send(32'h0022_18C2, RS, RT, {1'b0, 4'b1101, RT, 32'd3});         // rotr 3
    send(32'h0002_1900, RS, RT, {1'b0, 4'b1010, RT, 32'd4});         // sll 4
    send(32'h0022_1822, RS, RT, {1'b0, 4'b0110, RS, RT});            // sub
    send(32'h1022_0010, RS, RT, {1'b0, 4'b0110, RS, RT});            // beq
    send(32'h8C22_FFFC, RS, RT, {1'b0, 4'b0010, RS, 32'hFFFF_FFFC}); // lw -4
    send(32'h0800_0010, RS, RT, {1'b0, 4'b1000, 32'd0, 32'd0});      // j
    send(32'h0022_182A, RS, RT, {1'b0, 4'b0111, RS, RT});            // slt
    send(32'h7022_1802, RS, RT, {1'b0, 4'b1001, RS, RT});            // mul
    send(32'h0002_18C2, RS, RT, {1'b1, 4'b0000, 32'd0, 32'd0});      // srl: illegal
    drain();
  endtask

  task automatic test_back_to_back();
    logic [68:0] e1;
    e1 = {1'b0, 4'b0010, 32'd1, 32'd2};
    OutReady = 1'b0;
    InValid = 1'b1; Instr = 32'h0022_1820; RsData = 32'd1; RtData = 32'd2; // add
    sb.push_back(e1);
    tick();
    Instr = 32'h0022_1825; RsData = 32'd3; RtData = 32'd4;                 // or
    sb.push_back({1'b0, 4'b0001, 32'd3, 32'd4});
    tick();
    Instr = 32'h0022_1826; RsData = 32'd5; RtData = 32'd6;                 // xor, must be refused
    compared++;
    if (InReady !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_inready: got %b, expected 0", InReady);
    end
    tick();
    InValid = 1'b0;
    tick(); tick();
    compared++;
    if (OutValid !== 1'b1 || {Illegal, ALUControl, A, B} !== e1 || InReady !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_hold: got ov=%b ir=%b %h, expected ov=1 ir=0 %h",
               OutValid, InReady, {Illegal, ALUControl, A, B}, e1);
    end
    drain();
  endtask

  task automatic test_flush();
    OutReady = 1'b0;
    InValid = 1'b1; Instr = 32'h0022_1820; RsData = 32'd9;  RtData = 32'd9;  tick();
    Instr = 32'h0022_1824;                                  tick();
    Flush = 1'b1; Instr = 32'h0022_1826;                    tick();
    Flush = 1'b0; InValid = 1'b0;
    compared++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_full: got ov=%b ir=%b, expected ov=0 ir=1", OutValid, InReady);
    end
    // One entry held: the same-cycle input is a real transfer and must also vanish.
    InValid = 1'b1; Instr = 32'h0022_1820;                  tick();
    Flush = 1'b1; Instr = 32'h0022_1827;                    tick();
    Flush = 1'b0; InValid = 1'b0;
    compared++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_one: got ov=%b ir=%b, expected ov=0 ir=1", OutValid, InReady);
    end
    OutReady = 1'b1;
    tick(); tick(); tick();
    send(32'h0022_1827, 32'h0F0F_0000, 32'h0000_F0F0, {1'b0, 4'b0011, 32'h0F0F_0000, 32'h0000_F0F0}); // nor
    drain();
  endtask

  task automatic test_illegal();
    OutReady = 1'b0;
    send(32'hFC00_0000, RS, RT, {1'b1, 4'b0000, 32'd0, 32'd0});
    compared++;
    if (OutValid !== 1'b1 || {Illegal, ALUControl, A, B} !== {1'b1, 4'b0000, 64'd0}) begin
      mismatched++;
      $display("FAIL illegal: got ov=%b %h, expected ov=1 illegal payload", OutValid, {Illegal, ALUControl, A, B});
    end
    tick();
    drain();
  endtask

  task automatic test_reset_mid_stall();
    OutReady = 1'b0;
    InValid = 1'b1; Instr = 32'h0022_1820; RsData = 32'd11; RtData = 32'd12; tick();
    Instr = 32'h0022_1822;                                                   tick();
    Reset = 1'b1; Flush = 1'b1;                                              tick();
    Reset = 1'b0; Flush = 1'b0; InValid = 1'b0;
    compared++;
    if ({OutValid, InReady, Illegal, ALUControl, A, B} !== {1'b0, 1'b1, 1'b0, 4'd0, 64'd0}) begin
      mismatched++;
      $display("FAIL reset_mid_stall: got ov=%b ir=%b il=%b ctl=%h a=%h b=%h, expected ov=0 ir=1 all zero",
               OutValid, InReady, Illegal, ALUControl, A, B);
    end
    OutReady = 1'b1;
    send(32'h3422_00F0, 32'h0000_0F00, RT, {1'b0, 4'b0001, 32'h0000_0F00, 32'h0000_00F0}); // ori
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_decode_sweep();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the ALU's 4-bit ALUControl/A/B interface.
- Decodes a fetched MIPS instruction plus register-file read data into ALUControl and the final 32-bit A/B operands.
- Registers the results at the ID/EX boundary.
- Uses a valid/ready handshake with a 2-entry skid buffer, so EX-side stalls never drop or duplicate an instruction.

Parameters:
- DEPTH, 2, skid buffer entries; fixed at 2, any other value is illegal.
- SHAMT_W, 5, shift-amount field width.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Flush  input  1  discard all buffered entries (branch/jump redirect).
- InValid  input  1  Instr/RsData/RtData are valid this cycle.
- InReady  output  1  stage can accept an instruction this cycle.
- Instr  input  32  instruction word.
- RsData  input  32  register-file value of rs.
- RtData  input  32  register-file value of rt.
- OutValid  output  1  ALUControl/A/B/Illegal are valid.
- OutReady  input  1  EX stage accepts the output this cycle.
- ALUControl  output  4  ALU operation code.
- A  output  32  ALU operand A.
- B  output  32  ALU operand B.
- Illegal  output  1  instruction not decodable; ALUControl=0000, A=B=0.

Behaviour:
- Reset (sync, active-high): both entries invalid; OutValid=0, InReady=1, ALUControl=0, A=0, B=0, Illegal=0.
- Transfers:
  - Input transfer = InValid&InReady.
  - Output transfer = OutValid&OutReady.
  - Latency from input transfer to OutValid = 1 cycle when the buffer is empty.
- Buffer:
  - Entry0 drives the outputs; entry1 is the skid.
  - InReady = !entry1_valid, registered, so it does not depend combinationally on OutReady.
  - A simultaneous push and pop with one entry held gives a pop then a push; occupancy stays 1.
  - A push with 2 entries held cannot occur, because InReady=0.
  - Order is strictly FIFO.
- Output stability: while OutValid=1 and OutReady=0, ALUControl/A/B/Illegal must hold stable.
- Flush: next cycle both entries are invalid and OutValid=0. Any input transfer in the same cycle is discarded. Flush takes priority over push and pop. Reset takes priority over Flush.
- Decode, R-type (opcode 000000), by funct:
  - 100000/100001 -> ADD (0010), A=Rs, B=Rt.
  - 100010/100011 -> SUB (0110).
  - 100100 -> AND (0000).
  - 100101 -> OR (0001).
  - 100110 -> XOR (0100).
  - 100111 -> NOR (0011).
  - 101010/101011 -> SLT (0111).
  - 000000 -> SLL (1010), A=Rt, B=zext shamt.
  - 000010 with Instr[21]=1 -> ROTR (1101), A=Rt, B=zext shamt.
  - 001000 -> JUMP (1000), A=B=0.
- Decode, SPECIAL2 (011100):
  - funct 000010 -> MUL (1001), A=Rs, B=Rt.
  - funct 100001 -> CLO (1100), A=Rs, B=1.
  - funct 100000 -> CLZ (1100), A=Rs, B=0.
- Decode, I-type (A=Rs):
  - addi/addiu (001000/001001) -> ADD, B=sext imm.
  - slti (001010) -> SLT, B=sext imm.
  - andi/ori/xori (001100/001101/001110) -> AND/OR/XOR, B=zext imm.
  - lw/sw/lb/lh/sb/sh (100011/101011/100000/100001/101000/101001) -> ADD, B=sext imm.
  - beq/bne (000100/000101) -> SUB, B=Rt.
  - lui (001111) -> SLL, A=zext imm, B=16.
- Decode, J-type: j/jal (000010/000011) -> JUMP, A=B=0.
- Anything else sets Illegal=1, ALUControl=0000, A=B=0. It still flows through the buffer like a normal entry.
- Decode is combinational on the input side; only the decoded 69-bit payload {Illegal, ALUControl, A, B} is stored.

Decomposition:
- Shared package alu_defs_pkg holds:
  - ALUControl localparams: AND, OR, ADD, NOR, XOR, SUB, SLT, JUMP, MUL, SLL, SGT, CLO/CLZ, ROTR.
  - Opcode/funct constants.
  - The issue payload struct.
- The ALU must consume the same ALUControl constants.
- Sub-module alu_op_decode: pure combinational Instr/Rs/Rt -> payload.
- The top level holds the skid buffer and handshake.

Test Plan:
1. After Reset, push add $3,$1,$2 (Rs=5, Rt=7) with OutReady=1 -> next cycle OutValid=1, ALUControl=0010, A=5, B=7, Illegal=0.
2. Decode sweep:
   - addi imm=0xFFFF -> B=0xFFFFFFFF.
   - andi imm=0xFFFF -> B=0x0000FFFF.
   - lui imm=0x1234 -> ALUControl=1010, A=0x1234, B=16.
   - clo -> 1100/B=1; clz -> B=0.
   - rotr shamt=3 -> 1101, B=3.
3. Hold OutReady=0 and push 3 instructions back-to-back -> 2 accepted, then InReady=0. Outputs stay stable on instruction #1. Release OutReady -> #1 and #2 emerge in order, with no loss or duplication.
4. Buffer holds 2 entries, assert Flush with InValid=1 -> next cycle OutValid=0 and InReady=1. The flushed-cycle input never appears.
5. Opcode 111111 -> Illegal=1, ALUControl=0000, A=B=0, delivered through the handshake.
6. Assert Reset mid-stall with 2 entries held -> next cycle all outputs are at reset values, and a subsequent push flows normally.
